// File: rtl/tetris_board.sv
// Board datapath for the falling-block game: settled 10x20 board, one falling
// 4x4 piece, gravity/moves, merge, line deletion and game statistics.
module tetris_board #(
  parameter int DROP_TICKS = 25_000_000,
  parameter int SPAWN_X    = 3
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         load_block,
  input  logic         drop_block,
  input  logic         update_board_state,
  input  logic         shift_down,
  input  logic [15:0]  piece_shape,
  input  logic         move_left,
  input  logic         move_right,
  output logic         filled_under,
  output logic [19:0]  completed_lines,
  output logic [199:0] display_cells,
  output logic [15:0]  lines_cleared,
  output logic         game_over
);

  localparam int              CNT_W   = (DROP_TICKS > 1) ? $clog2(DROP_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DROP_TICKS - 1);
  localparam logic [3:0]      SPAWN_XL = 4'(SPAWN_X);

  // Row i occupies bits [i*10 +: 10]; column j is bit j within the row.
  typedef logic [19:0][9:0] board_t;

  board_t           board_q, board_d;
  logic [15:0]      mask_q, mask_d;
  logic [3:0]       x_q, x_d;
  logic [4:0]       y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      lines_q, lines_d;
  logic             over_q, over_d;

  board_t piece_cells, shifted;
  logic   tick, fall_blocked, row_found;
  int     top_full;

  // Cells outside the 10x20 field count as occupied.
  function automatic logic collide(input board_t b, input logic [15:0] m,
                                   input int xp, input int yp);
    logic hit;
    int   bx, by;
    hit = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        bx = xp + c;
        by = yp + r;
        if (m[4'(r * 4 + c)]) begin
          if (bx > 9 || by > 19) hit = 1'b1;
          else if (b[by[4:0]][bx[3:0]]) hit = 1'b1;
        end
      end
    end
    return hit;
  endfunction

  function automatic board_t overlay(input logic [15:0] m, input int xp, input int yp);
    board_t o;
    int     bx, by;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        bx = xp + c;
        by = yp + r;
        if (m[4'(r * 4 + c)] && bx <= 9 && by <= 19) o[by[4:0]][bx[3:0]] = 1'b1;
      end
    end
    return o;
  endfunction

  always_comb begin
    for (int i = 0; i < 20; i++) completed_lines[i] = &board_q[i];
  end

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    tick         = drop_block && (cnt_q == CNT_MAX);
    fall_blocked = collide(board_q, mask_q, int'(x_q), int'(y_q) + 1);
    filled_under = tick && fall_blocked;
    piece_cells  = overlay(mask_q, int'(x_q), int'(y_q));
    display_cells = board_q | piece_cells;
    lines_cleared = lines_q;
    game_over     = over_q;

    // Bottommost full row and the board with it removed.
    row_found = 1'b0;
    top_full  = 0;
    for (int i = 19; i >= 0; i--) begin
      if (!row_found && completed_lines[i]) begin
        row_found = 1'b1;
        top_full  = i;
      end
    end
    shifted = board_q;
    for (int i = 1; i < 20; i++) begin
      if (i <= top_full) shifted[i] = board_q[i-1];
    end
    shifted[0] = '0;

    board_d = board_q;
    mask_d  = mask_q;
    x_d     = x_q;
    y_d     = y_q;
    lines_d = lines_q;
    over_d  = over_q;
    cnt_d   = (drop_block && !tick) ? cnt_q + CNT_W'(1) : '0;

    if (load_block) begin
      mask_d = piece_shape;
      x_d    = SPAWN_XL;
      y_d    = '0;
      cnt_d  = '0;
      if (collide(board_q, piece_shape, SPAWN_X, 0)) over_d = 1'b1;
    end else if (update_board_state) begin
      board_d = board_q | piece_cells;
      mask_d  = '0;
    end else if (shift_down) begin
      if (row_found) begin
        board_d = shifted;
        if (lines_q != 16'hFFFF) lines_d = lines_q + 16'd1;
      end
    end else if (drop_block) begin
      if (tick) begin
        if (!fall_blocked) y_d = y_q + 5'd1;
      end else if (move_left && !move_right) begin
        if (x_q != 4'd0 && !collide(board_q, mask_q, int'(x_q) - 1, int'(y_q)))
          x_d = x_q - 4'd1;
      end else if (move_right && !move_left) begin
        if (!collide(board_q, mask_q, int'(x_q) + 1, int'(y_q)))
          x_d = x_q + 4'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      board_q <= '0;
      mask_q  <= '0;
      x_q     <= SPAWN_XL;
      y_q     <= '0;
      cnt_q   <= '0;
      lines_q <= '0;
      over_q  <= 1'b0;
    end else begin
      board_q <= board_d;
      mask_q  <= mask_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      lines_q <= lines_d;
      over_q  <= over_d;
    end
  end

endmodule

// File: tb/tb_tetris_board.sv
// Directed bench for tetris_board with DROP_TICKS = 4: fall/land, moves,
// single and double line clears, game over.
module tb_tetris_board;

  typedef logic [19:0][9:0] board_t;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic         load_block = 1'b0;
  logic         drop_block = 1'b0;
  logic         update_board_state = 1'b0;
  logic         shift_down = 1'b0;
  logic [15:0]  piece_shape = '0;
  logic         move_left = 1'b0;
  logic         move_right = 1'b0;
  logic         filled_under;
  logic [19:0]  completed_lines;
  logic [199:0] display_cells;
  logic [15:0]  lines_cleared;
  logic         game_over;

  int     checks = 0;
  int     errors = 0;
  board_t exp_b, exp_d;

  tetris_board #(.DROP_TICKS(4), .SPAWN_X(3)) dut (
    .clock              (clock),
    .resetn             (resetn),
    .load_block         (load_block),
    .drop_block         (drop_block),
    .update_board_state (update_board_state),
    .shift_down         (shift_down),
    .piece_shape        (piece_shape),
    .move_left          (move_left),
    .move_right         (move_right),
    .filled_under       (filled_under),
    .completed_lines    (completed_lines),
    .display_cells      (display_cells),
    .lines_cleared      (lines_cleared),
    .game_over          (game_over)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    load_block = 1'b0; drop_block = 1'b0; update_board_state = 1'b0;
    shift_down = 1'b0; move_left = 1'b0; move_right = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

  task automatic load(input logic [15:0] shape);
    piece_shape = shape;
    load_block = 1'b1;
    step();
    load_block = 1'b0;
  endtask

  // Each move is a one-cycle drop window starting from counter 0, so it never lands on a tick.
  task automatic move(input logic right, input int count);
    repeat (count) begin
      drop_block = 1'b1; move_right = right; move_left = !right;
      step();
      drop_block = 1'b0; move_right = 1'b0; move_left = 1'b0;
      step();
    end
  endtask

  task automatic land(input string tag);
    int n;
    n = 0;
    drop_block = 1'b1;
    step();
    while (filled_under !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    checks++;
    assert (n < 200) else begin
      errors++;
      $error("FAIL %s land timeout observed %0d cycles expected <200", tag, n);
    end
    drop_block = 1'b0;
    update_board_state = 1'b1;
    step();
    update_board_state = 1'b0;
  endtask

  initial begin
    // Reset
    do_reset();
    chk("reset display", display_cells, '0);
    chk("reset completed", {180'b0, completed_lines}, '0);
    chk("reset lines", {184'b0, lines_cleared}, '0);
    chk("reset flags", {198'b0, game_over, filled_under}, '0);

    // Fall and land: bar at x=3 covers columns 3..6 (10'h078)
    load(16'h000F);
    exp_d = '0; exp_d[0] = 10'h078;
    chk("spawn bar", display_cells, exp_d);
    drop_block = 1'b1;
    repeat (3) step();
    chk("no descent before 4 cycles", display_cells, exp_d);
    step();
    exp_d = '0; exp_d[1] = 10'h078;
    chk("first descent", display_cells, exp_d);
    repeat (74) step();
    exp_d = '0; exp_d[19] = 10'h078;
    chk("bar at row 19", display_cells, exp_d);
    chk("filled_under off non-tick", {199'b0, filled_under}, '0);
    step();
    chk("filled_under on landing tick", {199'b0, filled_under}, 200'd1);
    drop_block = 1'b0;
    #1;
    chk("filled_under off without drop", {199'b0, filled_under}, '0);
    update_board_state = 1'b1;
    step();
    update_board_state = 1'b0;
    exp_b = '0; exp_b[19] = 10'h078;
    chk("merge row 19", display_cells, exp_b);
    chk("merge not complete", {180'b0, completed_lines}, '0);

    // Moves
    do_reset();
    chk("reset clears board", display_cells, '0);
    load(16'h000F);
    move(1'b1, 1);
    exp_d = '0; exp_d[0] = 10'h0F0;
    chk("right to x4", display_cells, exp_d);
    move(1'b1, 3);
    exp_d = '0; exp_d[0] = 10'h3C0;
    chk("right stops at x6", display_cells, exp_d);
    move(1'b0, 7);
    exp_d = '0; exp_d[0] = 10'h00F;
    chk("left stops at x0", display_cells, exp_d);
    drop_block = 1'b1;
    repeat (3) step();
    move_right = 1'b1;
    step();
    move_right = 1'b0; drop_block = 1'b0;
    exp_d = '0; exp_d[1] = 10'h00F;
    chk("move on tick ignored", display_cells, exp_d);
    drop_block = 1'b1; move_left = 1'b1; move_right = 1'b1;
    step();
    drop_block = 1'b0; move_left = 1'b0; move_right = 1'b0;
    step();
    chk("both moves ignored", display_cells, exp_d);

    // Single line clear
    do_reset();
    load(16'h00F1);
    move(1'b0, 3);
    land("piece A");
    exp_b = '0; exp_b[18] = 10'h001; exp_b[19] = 10'h00F;
    chk("piece A merged", display_cells, exp_b);
    load(16'h0003);
    move(1'b1, 1);
    land("piece B");
    exp_b[19] = 10'h03F;
    chk("piece B merged", display_cells, exp_b);
    load(16'h000F);
    move(1'b1, 3);
    land("bar fill");
    exp_b[19] = 10'h3FF;
    chk("row 19 full", display_cells, exp_b);
    chk("completed row 19", {180'b0, completed_lines}, 200'h80000);
    shift_down = 1'b1;
    step();
    shift_down = 1'b0;
    exp_b = '0; exp_b[19] = 10'h001;
    chk("after single clear", display_cells, exp_b);
    chk("completed after clear", {180'b0, completed_lines}, '0);
    chk("lines after clear", {184'b0, lines_cleared}, 200'd1);
    shift_down = 1'b1;
    step();
    shift_down = 1'b0;
    chk("shift with nothing full", display_cells, exp_b);
    chk("lines unchanged", {184'b0, lines_cleared}, 200'd1);

    // Double clear
    do_reset();
    load(16'h00FF);
    move(1'b0, 3);
    land("P1");
    load(16'h00FF);
    move(1'b1, 1);
    land("P2");
    load(16'h0033);
    move(1'b1, 5);
    land("P3");
    load(16'h0001);
    move(1'b0, 3);
    land("P4");
    exp_b = '0; exp_b[17] = 10'h001; exp_b[18] = 10'h3FF; exp_b[19] = 10'h3FF;
    chk("double stack", display_cells, exp_b);
    chk("two completed", {180'b0, completed_lines}, 200'hC0000);
    shift_down = 1'b1;
    step();
    shift_down = 1'b0;
    chk("one completed left", {180'b0, completed_lines}, 200'h80000);
    shift_down = 1'b1;
    step();
    shift_down = 1'b0;
    exp_b = '0; exp_b[19] = 10'h001;
    chk("after double clear", display_cells, exp_b);
    chk("completed after double", {180'b0, completed_lines}, '0);
    chk("lines after double", {184'b0, lines_cleared}, 200'd2);

    // Game over
    do_reset();
    load(16'h0001);
    move(1'b1, 1);
    update_board_state = 1'b1;
    step();
    update_board_state = 1'b0;
    exp_b = '0; exp_b[0] = 10'h010;
    chk("blocker at row 0 col 4", display_cells, exp_b);
    chk("no game over yet", {199'b0, game_over}, '0);
    load(16'h000F);
    chk("game over on spawn", {199'b0, game_over}, 200'd1);
    exp_d = '0; exp_d[0] = 10'h078;
    chk("spawn still loaded", display_cells, exp_d);
    update_board_state = 1'b1;
    step();
    update_board_state = 1'b0;
    shift_down = 1'b1;
    step();
    shift_down = 1'b0;
    chk("game over sticky", {199'b0, game_over}, 200'd1);
    do_reset();
    chk("game over cleared by reset", {199'b0, game_over}, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
